// File: rtl/usage_pkg.sv
// Shared types and constants for the usage profiler and the plan selector it feeds.
package usage_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Operand width and ceiling of the plan selector's average-usage inputs.
  localparam int AVG_W   = 6;
  localparam int AVG_MAX = 63;

endpackage

// File: rtl/avg_sat.sv
// Divide a window sum by 2^SHIFT (floor) and clip the quotient to the selector range.
module avg_sat
  import usage_pkg::*;
#(
  parameter int SUM_W = 11,
  parameter int SHIFT = 3
) (
  input  logic [SUM_W-1:0] sum,
  output logic [AVG_W-1:0] avg,
  output logic             clip
);

  // Widened before shifting so narrow sums still yield a full AVG_W result.
  function automatic logic [AVG_W:0] shift_sat(input logic [SUM_W-1:0] s);
    logic [SUM_W+AVG_W-1:0] q;
    q = {{AVG_W{1'b0}}, s} >> SHIFT;
    if (q > (SUM_W+AVG_W)'(AVG_MAX)) begin
      return {1'b1, AVG_W'(AVG_MAX)};
    end
    return {1'b0, q[AVG_W-1:0]};
  endfunction

  assign {clip, avg} = shift_sat(sum);

endmodule

// File: rtl/usage_profiler.sv
// Accumulates a fixed window of daily talk/data records and hands the floor-averaged,
// saturated results to the plan selector through a valid/ready handshake.
module usage_profiler
  import usage_pkg::*;
#(
  parameter int LOG2_DAYS = 3,
  parameter int IN_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_talk,
  input  logic [IN_W-1:0]      in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AVG_W-1:0]     out_avgtalk,
  output logic [AVG_W-1:0]     out_avgdata,
  output logic                 out_sat,
  output logic [LOG2_DAYS-1:0] day_cnt
);

  localparam int SUM_W = IN_W + LOG2_DAYS;

  state_t            state_q;
  state_t            state_d;
  logic [SUM_W-1:0]  acc_talk_p0;
  logic [SUM_W-1:0]  acc_data_p0;
  logic [SUM_W-1:0]  sum_talk;
  logic [SUM_W-1:0]  sum_data;
  logic [AVG_W-1:0]  avg_talk;
  logic [AVG_W-1:0]  avg_data;
  logic              clip_talk;
  logic              clip_data;
  logic              accept;
  logic              last_day;
  logic              handshake;

  assign accept    = in_valid && in_ready;
  assign last_day  = accept && (day_cnt == '1);
  assign handshake = out_valid && out_ready;

  // Averages are taken from the sums including the record being accepted, so the
  // result registers load on the same edge that accepts the last day.
  assign sum_talk = acc_talk_p0 + SUM_W'(in_talk);
  assign sum_data = acc_data_p0 + SUM_W'(in_data);

  avg_sat #(
    .SUM_W (SUM_W),
    .SHIFT (LOG2_DAYS)
  ) u_avg_talk (
    .sum  (sum_talk),
    .avg  (avg_talk),
    .clip (clip_talk)
  );

  avg_sat #(
    .SUM_W (SUM_W),
    .SHIFT (LOG2_DAYS)
  ) u_avg_data (
    .sum  (sum_data),
    .avg  (avg_data),
    .clip (clip_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (last_day)  state_d = HOLD;
      HOLD:    if (handshake) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
    if (clr) begin
      state_d = ACCUM;
    end
  end

  // Accumulate stage -> registered result stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      day_cnt     <= '0;
      acc_talk_p0 <= '0;
      acc_data_p0 <= '0;
      out_avgtalk <= '0;
      out_avgdata <= '0;
      out_sat     <= 1'b0;
    end else if (clr) begin
      state_q     <= ACCUM;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      day_cnt     <= '0;
      acc_talk_p0 <= '0;
      acc_data_p0 <= '0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == ACCUM);
      out_valid <= (state_d == HOLD);
      if (accept) begin
        day_cnt     <= day_cnt + 1'b1;
        acc_talk_p0 <= sum_talk;
        acc_data_p0 <= sum_data;
      end
      if (last_day) begin
        out_avgtalk <= avg_talk;
        out_avgdata <= avg_data;
        out_sat     <= clip_talk | clip_data;
      end
      if (handshake) begin
        acc_talk_p0 <= '0;
        acc_data_p0 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_usage_profiler.sv
// Randomised and directed bench for usage_profiler with a window-level reference model
// and a scoreboard of expected averages checked by an independent monitor.
module tb_usage_profiler;

  localparam int L    = 3;
  localparam int N    = 1 << L;
  localparam int IN_W = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IN_W-1:0] in_talk = '0;
  logic [IN_W-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [5:0]      out_avgtalk;
  logic [5:0]      out_avgdata;
  logic            out_sat;
  logic [L-1:0]    day_cnt;

  always #5 clk = ~clk;

  usage_profiler #(.LOG2_DAYS(L), .IN_W(IN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_talk     (in_talk),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_avgtalk (out_avgtalk),
    .out_avgdata (out_avgdata),
    .out_sat     (out_sat),
    .day_cnt     (day_cnt)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int talk;
    int data;
    int sat;
  } res_t;

  res_t exp_q[$];
  int   win_t[$];
  int   win_d[$];
  bit   m_ready = 1'b0;
  bit   m_hold  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    win_t.delete();
    win_d.delete();
  endtask

  // Window-level reference: the day list, whether a result is pending, and readiness.
  task automatic model_edge();
    res_t r;
    int st, sd;
    if (!rst_n) begin
      model_clear();
      m_ready = 1'b0;
      m_hold  = 1'b0;
    end else if (clr) begin
      model_clear();
      m_ready = 1'b1;
      m_hold  = 1'b0;
    end else if (m_hold) begin
      if (out_ready) begin
        model_clear();
        m_hold  = 1'b0;
        m_ready = 1'b1;
      end
    end else if (!m_ready) begin
      m_ready = 1'b1;
    end else if (in_valid) begin
      win_t.push_back(int'(in_talk));
      win_d.push_back(int'(in_data));
      if (win_t.size() == N) begin
        st = 0;
        sd = 0;
        foreach (win_t[i]) st += win_t[i];
        foreach (win_d[i]) sd += win_d[i];
        r.talk = st / N;
        r.data = sd / N;
        r.sat  = (r.talk > 63 || r.data > 63) ? 1 : 0;
        if (r.talk > 63) r.talk = 63;
        if (r.data > 63) r.data = 63;
        exp_q.push_back(r);
        m_hold  = 1'b1;
        m_ready = 1'b0;
      end
    end
  endtask

  task automatic cycle(input bit v, input int t, input int d, input bit ordy, input bit c);
    in_valid  = v;
    in_talk   = IN_W'(t);
    in_data   = IN_W'(d);
    out_ready = ordy;
    clr       = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("in_ready", int'(in_ready), int'(m_ready));
    chk("out_valid", int'(out_valid), int'(m_hold));
    chk("day_cnt", int'(day_cnt), m_hold ? 0 : (win_t.size() % N));
  endtask

  // Monitor: pops an expected result when out_valid rises, then holds it to that value.
  bit   prev_v = 1'b0;
  res_t cur;
  always @(negedge clk) begin
    if (out_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        cur = exp_q.pop_front();
        chk("avgtalk", int'(out_avgtalk), cur.talk);
        chk("avgdata", int'(out_avgdata), cur.data);
        chk("sat", int'(out_sat), cur.sat);
      end
    end else if (out_valid) begin
      chk("hold_avgtalk", int'(out_avgtalk), cur.talk);
      chk("hold_avgdata", int'(out_avgdata), cur.data);
      chk("hold_sat", int'(out_sat), cur.sat);
    end
    prev_v = out_valid;
  end

  initial begin
    int dseq[8];
    dseq = '{1, 2, 0, 0, 0, 0, 0, 0};

    // Reset values
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_avgtalk", int'(out_avgtalk), 0);
    chk("rst_avgdata", int'(out_avgdata), 0);
    chk("rst_sat", int'(out_sat), 0);
    chk("rst_day_cnt", int'(day_cnt), 0);
    cycle(1, 5, 5, 1, 0);
    rst_n = 1'b1;
    cycle(0, 0, 0, 1, 0);

    // Basic average: talk 10..80, data 7
    for (int i = 0; i < N; i++) cycle(1, 10 * (i + 1), 7, 1, 0);
    cycle(0, 0, 0, 1, 0);

    // Saturation/truncation, then backpressure on that result
    for (int i = 0; i < N; i++) cycle(1, 100, dseq[i], 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, $urandom_range(0, 255), $urandom_range(0, 255), 0, 0);
    cycle(1, 200, 200, 1, 0);
    cycle(1, 16, 16, 1, 0);
    chk("bp_day_cnt", int'(day_cnt), 1);
    for (int i = 1; i < N; i++) cycle(1, 16, 16, 1, 0);
    cycle(0, 0, 0, 1, 0);

    // Mid-window clear
    for (int i = 0; i < 4; i++) cycle(1, 60, 3, 1, 0);
    cycle(0, 0, 0, 1, 1);
    chk("clr_day_cnt", int'(day_cnt), 0);
    for (int i = 0; i < N; i++) cycle(1, 8, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);

    // clr together with the final record, then clr together with out_ready
    for (int i = 0; i < N - 1; i++) cycle(1, 50, 50, 1, 0);
    cycle(1, 50, 50, 1, 1);
    chk("clr_last_valid", int'(out_valid), 0);
    for (int i = 0; i < N; i++) cycle(1, 20, 30, 1, 0);
    cycle(0, 0, 0, 1, 1);
    chk("clr_hs_ready", int'(in_ready), 1);

    // Asynchronous reset while holding a result
    for (int i = 0; i < N; i++) cycle(1, 40, 9, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_in_ready", int'(in_ready), 0);
    chk("arst_avgtalk", int'(out_avgtalk), 0);
    chk("arst_avgdata", int'(out_avgdata), 0);
    chk("arst_sat", int'(out_sat), 0);
    chk("arst_day_cnt", int'(day_cnt), 0);
    model_clear();
    m_ready = 1'b0;
    m_hold  = 1'b0;
    @(negedge clk);
    cycle(1, 7, 7, 1, 0);
    rst_n = 1'b1;
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < N; i++) cycle(1, 24, 33, 1, 0);
    cycle(0, 0, 0, 1, 0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 90),
            $urandom_range(0, 127), ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3));
    end
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 0);
    chk("leftover_results", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
